instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Decode stage of the 16-bit CPU, directly upstream of the immediate generator. Buffers fetched instructions in a 2-entry FIFO and decodes the opcode into register addresses, control strobes and the `imm_Control_6`/`imm_Control_3` selects. Holds one decoded instruction in an output register presented to the operand/immediate stage with a valid/ready handshake. Supports a synchronous flush and a HALT stop condition.

## Interface
- `FIFO_DEPTH`, 2, input buffer entries; only 2 is supported.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous pipeline flush, used on branch redirect
- `in_valid`  in  1  fetch presents an instruction
- `in_instr`  in  16  fetched instruction
- `in_ready`  out  1  stage accepts `in_instr` this cycle
- `out_valid`  out  1  decoded instruction held in the output register
- `out_ready`  in  1  downstream consumes the output this cycle
- `instructionOut`  out  16  raw instruction, feeds the immediate generator's `instructionIn`
- `out_opcode`  out  4  `instr[15:12]`
- `out_rd` / `out_rs1` / `out_rs2`  out  3 each  `instr[11:9]` / `[8:6]` / `[5:3]`
- `imm_Control_6`  out  1  6-bit immediate select
- `imm_Control_3`  out  1  3-bit immediate select
- `reg_write`, `mem_read`, `mem_write`, `branch`  out  1 each  control strobes
- `illegal`  out  1  undefined opcode
- `halted`  out  1  HALT has been decoded; sticky

## Operation
- Opcode map:
  - 0 NOP: no strobes.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: `reg_write`.
  - 5 ADDI: `reg_write`, imm6.
  - 6 LW: `reg_write`, `mem_read`, imm6.
  - 7 SW: `mem_write`, imm6.
  - 8 SHLI, 9 SHRI: `reg_write`, imm3.
  - A BEQ: `branch`, imm6.
  - F HALT: no strobes.
  - B–E: `illegal`=1 and every strobe and imm select 0.
- `imm_Control_6` and `imm_Control_3` are never both 1.
- FIFO: `in_ready` = `!full && !halted && !flush`, and is 0 while `reset_n` is low. A write occurs when `in_valid && in_ready`.
- Output register states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
  - Load: the FIFO head moves into the output register when the FIFO is non-empty and (EMPTY, or FULL with `out_ready`=1).
  - Drain: FULL with `out_ready`=1 and an empty FIFO returns to EMPTY.
- All decoded outputs are registered, computed from the head at load time, and held stable while `out_valid && !out_ready`.
- HALT: `halted` sets when a HALT opcode loads into the output register. Once set, `in_ready`=0. Instructions already in the FIFO continue to drain. `halted` clears only on `flush` or reset.
- `flush` at a clock edge:
  - clears the FIFO and the output register (`out_valid`=0) and clears `halted`;
  - drops any `in_valid` presented in the same cycle;
  - takes priority over load and consume in the same cycle.
- Simultaneous FIFO write and read while full is not possible, because `in_ready`=0 when full.
- Simultaneous write and read at one entry: the count stays at 1 and the data order is preserved.

## Timing
- Reset values: `out_valid`, `halted`, `illegal`, all strobes, both imm selects, `instructionOut`, `out_opcode`/`rd`/`rs1`/`rs2` are all 0. FIFO is empty.
- Latency: an instruction accepted at edge E is written to the FIFO at E. It loads into the output register at E+1 when the output path is free, so `out_valid` is high in the cycle after E+1.
- Throughput: with `out_ready` held at 1, the stage accepts and emits one instruction per cycle.
- Back-pressure: with `out_ready`=0, two more instructions are accepted, then `in_ready` drops in the following cycle.
- Reset assertion mid-operation clears all state immediately (asynchronous). Deassertion is sampled at the clock edge.

## Test plan
- Reset then stream `0x5A47` (ADDI), `0x8B05` (SHLI), `0x1050` (ADD) with `out_ready`=1. Required responses:
  - ADDI: `imm_Control_6`=1, `reg_write`=1, `out_rd`=5.
  - SHLI: `imm_Control_3`=1.
  - ADD: both imm selects 0.
  - Each output appears 2 edges after acceptance, one per cycle.
- Hold `out_ready`=0 and offer 4 instructions. Required: exactly 3 accepted (1 in the output register + 2 in the FIFO), then `in_ready`=0. Release `out_ready` and the 3 emerge in order.
- Opcodes 0xB–0xE: `illegal`=1 with all strobes 0. `0x7123` (SW): `mem_write`=1, `reg_write`=0.
- `0xF000` HALT followed by `0x1000`. Required:
  - `halted`=1 after HALT loads, and `in_ready` stays 0.
  - Instructions already buffered before HALT still drain.
  - `flush` clears `halted` and restores `in_ready`=1.
- Assert `flush` with the FIFO full, `out_valid`=1 and `in_valid`=1. Required: next cycle `out_valid`=0, FIFO empty, and the presented instruction is never output.
- Pulse `reset_n` low mid-stream, asynchronous to `clk`. Required: all outputs 0 immediately, and normal acceptance after deassertion.

Source files
------------

// File: rtl/instr_decode_stage.sv
// sync_fifo: small generic synchronous FIFO with a synchronous clear.
// Latency: data written at edge E is visible on rd_dat after E (no bypass).
// Backpressure: writes while full and reads while empty are ignored; caller gates on full/empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; clear wins over any same-cycle read or write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// instr_decode_stage: buffers fetched instructions and decodes them into a registered output slot.
// Latency: accepted at edge E, written to FIFO at E, loaded to output at E+1 (2 edges to out_valid).
// Backpressure: in_ready = !full && !halted && !flush; output slot holds while out_valid && !out_ready.
module instr_decode_stage #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] instructionOut,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_rd,
    output logic [2:0]  out_rs1,
    output logic [2:0]  out_rs2,
    output logic        imm_Control_6,
    output logic        imm_Control_3,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        illegal,
    output logic        halted
);
    typedef struct packed {
        logic [15:0] instr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        imm6;
        logic        imm3;
        logic        illegal;
    } dec_t;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state_q;
    state_t      state_d;
    dec_t        dec_d;
    dec_t        dec_q;
    logic [15:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        load;
    logic        halted_q;

    // reset_n term keeps in_ready low during reset regardless of FIFO state.
    assign in_ready = reset_n && !fifo_full && !halted_q && !flush;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .wr_vld  (in_valid && in_ready),
        .wr_dat  (in_instr),
        .rd_rdy  (load),
        .rd_dat  (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output slot state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO pop; flush overrides both load and consume.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            load    = 1'b0;
            state_d = EMPTY;
        end
    end

    // Opcode decode of the FIFO head; imm6 and imm3 are mutually exclusive by construction.
    always_comb begin
        dec_d       = '0;
        dec_d.instr = fifo_head;
        case (fifo_head[15:12])
            4'h0, 4'hF: ;
            4'h1, 4'h2, 4'h3, 4'h4: dec_d.reg_write = 1'b1;
            4'h5: begin
                dec_d.reg_write = 1'b1;
                dec_d.imm6      = 1'b1;
            end
            4'h6: begin
                dec_d.reg_write = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.imm6      = 1'b1;
            end
            4'h7: begin
                dec_d.mem_write = 1'b1;
                dec_d.imm6      = 1'b1;
            end
            4'h8, 4'h9: begin
                dec_d.reg_write = 1'b1;
                dec_d.imm3      = 1'b1;
            end
            4'hA: begin
                dec_d.branch = 1'b1;
                dec_d.imm6   = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    // Decoded output register; only changes on a load so it holds under back-pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_q <= '0;
        end else if (load) begin
            dec_q <= dec_d;
        end
    end

    // Sticky HALT flag, set when HALT reaches the output slot, cleared only by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted_q <= 1'b0;
        end else if (flush) begin
            halted_q <= 1'b0;
        end else if (load && (fifo_head[15:12] == 4'hF)) begin
            halted_q <= 1'b1;
        end
    end

    assign out_valid      = (state_q == FULL);
    assign instructionOut = dec_q.instr;
    assign out_opcode     = dec_q.instr[15:12];
    assign out_rd         = dec_q.instr[11:9];
    assign out_rs1        = dec_q.instr[8:6];
    assign out_rs2        = dec_q.instr[5:3];
    assign imm_Control_6  = dec_q.imm6;
    assign imm_Control_3  = dec_q.imm3;
    assign reg_write      = dec_q.reg_write;
    assign mem_read       = dec_q.mem_read;
    assign mem_write      = dec_q.mem_write;
    assign branch         = dec_q.branch;
    assign illegal        = dec_q.illegal;
    assign halted         = halted_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: scoreboard of accepted instructions checked at output handshake.
// Inputs change 1 time unit after posedge; DUT is sampled on negedge.
// Covers streaming, back-pressure, illegal opcodes, HALT, flush and async reset.
module tb_instr_decode_stage;
    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instructionOut;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_rs1;
    logic [2:0]  out_rs2;
    logic        imm_Control_6;
    logic        imm_Control_3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
    logic        halted;

    typedef struct {
        logic [15:0] instr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   chk_lat = 0;

    instr_decode_stage #(.FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instructionOut (instructionOut),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .imm_Control_6  (imm_Control_6),
        .imm_Control_3  (imm_Control_3),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .branch         (branch),
        .illegal        (illegal),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference decode: {illegal, reg_write, mem_read, mem_write, branch, imm6, imm3}.
    function automatic logic [6:0] exp_ctrl(input logic [15:0] instr);
        case (instr[15:12])
            4'h0, 4'hF:             return 7'b0000000;
            4'h1, 4'h2, 4'h3, 4'h4: return 7'b0100000;
            4'h5:                   return 7'b0100010;
            4'h6:                   return 7'b0110010;
            4'h7:                   return 7'b0001010;
            4'h8, 4'h9:             return 7'b0100001;
            4'hA:                   return 7'b0000110;
            default:                return 7'b1000000;
        endcase
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", instructionOut, 16'hxxxx);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("instr", {16'h0, instructionOut}, {16'h0, e.instr});
                        check("fields", {19'h0, out_opcode, out_rd, out_rs1, out_rs2},
                              {19'h0, e.instr[15:3]});
                        check("ctrl", {25'h0, illegal, reg_write, mem_read, mem_write, branch,
                                       imm_Control_6, imm_Control_3}, {25'h0, exp_ctrl(e.instr)});
                        if (chk_lat) check("latency", cyc - e.cyc, 2);
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{instr: in_instr, cyc: cyc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] instr);
        bit ok = 0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accept", ok, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
        end
        check(tag, q.size(), 0);
        tick();
    endtask

    logic [15:0] bp [4] = '{16'h2111, 16'h3222, 16'h6A33, 16'h4444};
    logic [15:0] il [5] = '{16'hB000, 16'hC123, 16'hD7FF, 16'hEFFF, 16'h7123};

    initial begin
        int acc;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        out_ready = 1'b0;

        // Reset values.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_instr", instructionOut, 0);
        check("rst_fields", {out_opcode, out_rd, out_rs1, out_rs2}, 0);
        check("rst_ctrl", {illegal, reg_write, mem_read, mem_write, branch,
                           imm_Control_6, imm_Control_3, halted}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Stream ADDI, SHLI, ADD at full rate.
        out_ready = 1'b1;
        chk_lat   = 1;
        send(16'h5A47);
        send(16'h8B05);
        send(16'h1050);
        wait_drain("drain_stream");
        chk_lat = 0;

        // Back-pressure: 3 accepted, 4th held off.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = bp[i];
            @(negedge clk);
            if (!in_ready) break;
            acc++;
            tick();
        end
        check("bp_accepted", acc, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("drain_bp");

        // Illegal opcodes and SW.
        foreach (il[i]) send(il[i]);
        wait_drain("drain_illegal");

        // HALT: the instruction taken before halted sets still drains; nothing after.
        send(16'hF000);
        send(16'h1000);
        in_valid = 1'b1;
        in_instr = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_flag", halted, 1);
            check("halt_in_ready", in_ready, 0);
            tick();
        end
        check("halt_drained", q.size(), 0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_halted", halted, 0);
        check("flush_restore_rdy", in_ready, 1);
        tick();

        // Flush with FIFO full, output valid and a presented instruction.
        out_ready = 1'b0;
        send(16'h2AAA);
        send(16'h3BBB);
        send(16'h4CCC);
        in_valid = 1'b1;
        in_instr = 16'h1234;
        flush    = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_fifo_empty", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_output", out_valid, 0);
        end
        tick();

        // Async reset mid-stream.
        out_ready = 1'b0;
        send(16'h6ABC);
        send(16'h1111);
        #3;
        reset_n = 1'b0;
        #1;
        q.delete();
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_instr", instructionOut, 0);
        check("arst_ctrl", {illegal, reg_write, mem_read, mem_write, branch,
                            imm_Control_6, imm_Control_3, halted}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        chk_lat   = 1;
        send(16'h9C28);
        send(16'hA1C0);
        wait_drain("drain_post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
